// File: rtl/ysyx_041461_sram_ctrl.sv
// SRAM controller: valid/ready request port, 2-entry in-order read response buffer.
// Optional power-on zero sweep of the array when YSYX_041461_SRAM_INIT_EN is defined.
module ysyx_041461_sram_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_e;

`ifdef YSYX_041461_SRAM_INIT_EN
    localparam state_e RESET_STATE = INIT;
`else
    localparam state_e RESET_STATE = RUN;
`endif

    state_e            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              push, pop, wr_acc, mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata, merged;

`ifdef YSYX_041461_SRAM_INIT_EN
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              sweep_we;
`endif

    // RST gates req_ready so no request can be seen as accepted while reset is held
    assign req_ready  = (state_q == RUN) && (count_q < 2'd2) && !RST;
    assign resp_valid = (count_q != 2'd0);
    assign resp_rdata = resp_valid ? buf_q[rd_ptr_q] : '0;
    assign push       = req_valid && req_ready && !req_wen;
    assign wr_acc     = req_valid && req_ready && req_wen;
    assign pop        = resp_valid && resp_ready;
    assign merged     = (req_wdata & req_wmask) | (mem_q[req_addr] & ~req_wmask);

    always_comb begin
        state_d = state_q;
`ifdef YSYX_041461_SRAM_INIT_EN
        sweep_d  = sweep_q;
        sweep_we = (state_q == INIT) && !RST;
        if (state_q == INIT) begin
            sweep_d = sweep_q + ADDR_W'(1);
            if (sweep_q == {ADDR_W{1'b1}}) state_d = RUN;
        end
        mem_we    = sweep_we || wr_acc;
        mem_waddr = sweep_we ? sweep_q : req_addr;
        mem_wdata = sweep_we ? '0 : merged;
        busy      = (state_q == INIT);
`else
        mem_we    = wr_acc;
        mem_waddr = req_addr;
        mem_wdata = merged;
        busy      = 1'b0;
`endif
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= RESET_STATE;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
`ifdef YSYX_041461_SRAM_INIT_EN
            sweep_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
`ifdef YSYX_041461_SRAM_INIT_EN
            sweep_q  <= sweep_d;
`endif
        end
    end

    // Array and response data carry no reset; the buffer snapshots the word at accept time
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        if (push)   buf_q[wr_ptr_q] <= mem_q[req_addr];
    end

endmodule

// File: doc/ysyx_041461_sram_ctrl.md
YSYX_041461_SRAM_CTRL -- requirements
Module: ysyx_041461_sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words SHALL be stored.
REQ-002 Parameter DATA_W, default 128, word width in bits.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 req_wen  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  word address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 req_wmask  input  DATA_W  per-bit write enable, active-high (1 = bit written).
REQ-011 resp_valid  output  1  read data available at buffer head.
REQ-012 resp_ready  input  1  consumer pops head when resp_valid && resp_ready at a rising edge.
REQ-013 resp_rdata  output  DATA_W  read data at buffer head.
REQ-014 busy  output  1  initialisation sweep in progress.

Function
REQ-015 FSM states INIT and RUN; INIT -> RUN after the sweep's last address (DEPTH-1) is written; RUN is terminal until reset.
REQ-016 req_ready SHALL equal (state == RUN) && (count < 2), where count is response-buffer occupancy; it SHALL NOT depend combinationally on resp_ready or req_valid.
REQ-017 Accepted write: mem[addr] <= (wdata & wmask) | (mem[addr] & ~wmask) at the accepting edge; no response generated.
REQ-018 Accepted read: mem[addr] captured into the 2-entry in-order response buffer at the accepting edge; resp_valid SHALL be 1 the following cycle (latency 1).
REQ-019 Buffered data SHALL be a snapshot; writes accepted after a read SHALL NOT alter that read's returned data.
REQ-020 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-021 Simultaneous push and pop: count unchanged, order preserved; with resp_ready held 1, one read per cycle SHALL be sustained.
REQ-022 resp_rdata SHALL be all-zero whenever resp_valid = 0 (no random or X output).
REQ-023 Pop with count = 0 SHALL have no effect; push with count = 2 cannot occur (req_ready = 0).
REQ-024 Address and sweep counters SHALL be ADDR_W bits and wrap modulo DEPTH.

Reset
REQ-025 While RST = 1: req_ready = 0, resp_valid = 0, resp_rdata = 0, count = 0, sweep counter = 0.
REQ-026 busy SHALL be 1 during reset iff YSYX_041461_SRAM_INIT_EN is defined, else 0.
REQ-027 Reset asserted mid-operation SHALL discard buffered responses immediately; reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-028 Memory array contents SHALL NOT be cleared by reset itself.

Configuration
REQ-029 Macro YSYX_041461_SRAM_INIT_EN defined: after reset release, state INIT writes zero to addresses 0..DEPTH-1, one per cycle, busy = 1 and req_ready = 0 for exactly DEPTH cycles, then RUN.
REQ-030 Macro undefined: reset leaves the FSM in RUN, busy constant 0, array contents undefined until written, req_ready = 1 the first cycle after reset release.

Verification
REQ-031 INIT_EN defined, ADDR_W = 6: release RST -> busy = 1, req_ready = 0 for 64 cycles; then read addr 63 -> resp_rdata = 0 one cycle later.
REQ-032 After init: write addr 5, wdata = all-ones, wmask = 0x...00FF00 -> read addr 5 returns 0x...00FF00.
REQ-033 resp_ready = 1, reads addr 0,1,2,3 on consecutive cycles (preloaded 0xA0..0xA3) -> resp_valid 1 for four consecutive cycles starting one cycle after first accept, data 0xA0..0xA3 in order.
REQ-034 resp_ready = 0, issue reads addr 1,2,3 -> two accepted, req_ready = 0 after second; raise resp_ready -> data of addr 1 then 2, third read then accepted.
REQ-035 Read addr 7 (value 0x11) accepted, write addr 7 = 0x22 next cycle while resp_ready = 0 -> popped data 0x11; subsequent read of addr 7 -> 0x22.
REQ-036 Two responses buffered, assert RST asynchronously -> resp_valid and resp_rdata go 0 without a clock edge; after release no stale response appears.
